fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage pipeline: owns the PC register, drives the instruction-memory request, and holds the IF/ID pipeline register consumed by decode. It obeys the load-use hold from the hazard unit (`pc_if_write`) and the branch/jump redirect from the resolve stage. It tolerates a multi-cycle instruction memory through a three-state fetch FSM and a one-entry holding buffer.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_stage_ifid_reg.sv | 24 ++
 rtl/fetch_stage.sv | 89 ++++++++
 tb/tb_fetch_stage.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
package fetch_pkg;
    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} fetch_state_t;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
    localparam logic [31:0] PC_STEP = 32'd4;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } ifid_t;
endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// ifid_reg: IF/ID pipeline register with flush (priority) over load, else hold.
module ifid_reg
    import fetch_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load_i,
    input  logic  flush_i,
    input  ifid_t d_i,
    output ifid_t q_o
);
    ifid_t q_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '{valid: 1'b0, pc: '0, pc_plus4: '0, instr: INSTR_NOP};
        end else if (flush_i) begin
            q_q.valid <= 1'b0;
            q_q.instr <= INSTR_NOP;
        end else if (load_i) begin
            q_q <= d_i;
        end
    end
    assign q_o = q_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, instruction-memory request FSM with a one-entry
// holding buffer, and the IF/ID register feeding decode.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_if_write,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_instr
);
    fetch_state_t state_q;
    logic [31:0]  pc_q, buf_pc_q, buf_instr_q, drain_addr_q;
    logic [31:0]  target, src_pc;
    logic         ifid_load, ifid_flush;
    ifid_t        ifid_d, ifid_q;

    always_comb begin
        target     = redirect_pc & ~32'h3;
        src_pc     = (state_q == HOLD) ? buf_pc_q : pc_q;
        ifid_d     = '{valid: 1'b1, pc: src_pc, pc_plus4: src_pc + PC_STEP,
                       instr: (state_q == HOLD) ? buf_instr_q : imem_rdata};
        // DRAIN keeps IF/ID a bubble; a FETCH wait with write enabled inserts one
        ifid_flush = redirect_valid || state_q == DRAIN ||
                     (state_q == FETCH && !imem_ready && pc_if_write);
        ifid_load  = pc_if_write && (state_q == HOLD || (state_q == FETCH && imem_ready));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            buf_pc_q     <= '0;
            buf_instr_q  <= INSTR_NOP;
            drain_addr_q <= '0;
        end else if (redirect_valid) begin
            pc_q        <= target;
            buf_pc_q    <= '0;
            buf_instr_q <= INSTR_NOP;
            // an unanswered request must still be drained; a ready this cycle ends it
            state_q     <= (!imem_ready && state_q != HOLD) ? DRAIN : FETCH;
            if (state_q == FETCH && !imem_ready) drain_addr_q <= pc_q;
        end else begin
            case (state_q)
                FETCH: if (imem_ready) begin
                    if (pc_if_write) pc_q <= pc_q + PC_STEP;
                    else begin
                        buf_pc_q    <= pc_q;
                        buf_instr_q <= imem_rdata;
                        state_q     <= HOLD;
                    end
                end
                HOLD: if (pc_if_write) begin
                    pc_q    <= buf_pc_q + PC_STEP;
                    state_q <= FETCH;
                end
                DRAIN: if (imem_ready) state_q <= FETCH;
                default: state_q <= FETCH;
            endcase
        end
    end

    assign imem_req  = rst_n && state_q != HOLD;
    assign imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;

    ifid_reg u_ifid (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (ifid_load),
        .flush_i(ifid_flush),
        .d_i    (ifid_d),
        .q_o    (ifid_q)
    );

    assign if_id_valid    = ifid_q.valid;
    assign if_id_pc       = ifid_q.pc;
    assign if_id_pc_plus4 = ifid_q.pc_plus4;
    assign if_id_instr    = ifid_q.instr;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed test-plan steps followed by a random run checked
// against an instruction-stream model (expected next PC, bubbles, holds).
module tb_fetch_stage;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        pc_if_write = 1'b0, redirect_valid = 1'b0, imem_ready = 1'b0;
    logic [31:0] redirect_pc = '0, imem_rdata = '0;
    logic        imem_req, if_id_valid;
    logic [31:0] imem_addr, if_id_pc, if_id_pc_plus4, if_id_instr;
    int          n_cmp = 0, n_err = 0;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .pc_if_write(pc_if_write),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
        .if_id_pc_plus4(if_id_pc_plus4), .if_id_instr(if_id_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic wr, input logic rd, input logic [31:0] rpc, input logic rdy);
        pc_if_write    = wr;
        redirect_valid = rd;
        redirect_pc    = rpc;
        imem_ready     = rdy && imem_req;
        imem_rdata     = mem(imem_addr);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, 32'(if_id_valid), 32'd1);
        chk({tag, "_pc"}, if_id_pc, pc);
        chk({tag, "_pc4"}, if_id_pc_plus4, pc + 32'd4);
        chk({tag, "_instr"}, if_id_instr, mem(pc));
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, 32'(if_id_valid), 32'd0);
        chk({tag, "_instr"}, if_id_instr, 32'd0);
    endtask

    initial begin
        logic        wr, rd, rdy, p_wait, pv;
        logic [31:0] rpc, p_addr, ppc, ppc4, pins, exp_pc;
        int          loads;
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk_bubble("rst");
        chk("rst_pc", if_id_pc, 32'd0);
        chk("rst_pc4", if_id_pc_plus4, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_req", 32'(imem_req), 32'd1);
        chk("rel_addr", imem_addr, 32'd0);
        // zero-wait streaming
        cyc(1, 0, 0, 1); chk_ifid("seq0", 32'h0);
        cyc(1, 0, 0, 1); chk_ifid("seq1", 32'h4);
        cyc(1, 0, 0, 1); chk_ifid("seq2", 32'h8);
        // two wait cycles
        cyc(1, 0, 0, 0); chk_bubble("wait0"); chk("wait0_addr", imem_addr, 32'hC);
        cyc(1, 0, 0, 0); chk_bubble("wait1"); chk("wait1_addr", imem_addr, 32'hC);
        cyc(1, 0, 0, 1); chk_ifid("wait_done", 32'hC);
        // ready during stall -> hold
        cyc(0, 0, 0, 1); chk_ifid("hold0", 32'hC); chk("hold0_req", 32'(imem_req), 32'd0);
        cyc(0, 0, 0, 0); chk_ifid("hold1", 32'hC); chk("hold1_req", 32'(imem_req), 32'd0);
        cyc(0, 0, 0, 0); chk_ifid("hold2", 32'hC); chk("hold2_req", 32'(imem_req), 32'd0);
        cyc(1, 0, 0, 0); chk_ifid("release", 32'h10);
        chk("release_addr", imem_addr, 32'h14); chk("release_req", 32'(imem_req), 32'd1);
        // redirect while a request is pending
        cyc(1, 0, 0, 0); chk_bubble("pend");
        cyc(1, 1, 32'h0040_0102, 0); chk_bubble("drain0");
        chk("drain_addr", imem_addr, 32'h14); chk("drain_req", 32'(imem_req), 32'd1);
        cyc(1, 0, 0, 1); chk_bubble("drain_done");
        chk("target_addr", imem_addr, 32'h0040_0100);
        cyc(1, 0, 0, 1); chk_ifid("target", 32'h0040_0100);
        // redirect while in HOLD with stall
        cyc(0, 0, 0, 1); chk("hold_req", 32'(imem_req), 32'd0);
        cyc(0, 1, 32'h0000_0200, 0); chk_bubble("hold_flush");
        chk("hold_flush_addr", imem_addr, 32'h200); chk("hold_flush_req", 32'(imem_req), 32'd1);
        cyc(1, 0, 0, 1); chk_ifid("hold_target", 32'h200);
        // wrap-around
        cyc(1, 1, 32'hFFFF_FFFF, 1); chk_bubble("wrap_redir");
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        cyc(1, 0, 0, 1); chk_ifid("wrap", 32'hFFFF_FFFC);
        chk("wrap_pc4", if_id_pc_plus4, 32'h0); chk("wrap_addr1", imem_addr, 32'h0);
        // random run against the stream model
        exp_pc = 32'h0;
        loads  = 0;
        for (int i = 0; i < 3000; i++) begin
            wr  = ($urandom % 4) != 0;
            rd  = ($urandom % 12) == 0;
            rpc = $urandom;
            rdy = ($urandom % 3) != 0;
            p_wait = imem_req && !rdy;
            p_addr = imem_addr;
            pv = if_id_valid; ppc = if_id_pc; ppc4 = if_id_pc_plus4; pins = if_id_instr;
            cyc(wr, rd, rpc, rdy);
            if (p_wait && imem_req) chk("r_addr_stable", imem_addr, p_addr);
            if (rd) begin
                chk_bubble("r_redir");
                exp_pc = rpc & ~32'h3;
            end else if (wr) begin
                if (if_id_valid) begin
                    chk_ifid("r_load", exp_pc);
                    exp_pc = exp_pc + 32'd4;
                    loads++;
                end else begin
                    chk("r_bubble_instr", if_id_instr, 32'd0);
                end
            end else begin
                chk("r_hold_valid", 32'(if_id_valid), 32'(pv));
                chk("r_hold_pc", if_id_pc, ppc);
                chk("r_hold_pc4", if_id_pc_plus4, ppc4);
                chk("r_hold_instr", if_id_instr, pins);
            end
        end
        chk("r_liveness", 32'(loads > 200), 32'd1);
        // asynchronous reset mid-run
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(imem_req), 32'd0);
        chk_bubble("arst");
        chk("arst_pc", if_id_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_addr", imem_addr, 32'd0);
        cyc(1, 0, 0, 1); chk_ifid("arst_first", 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
